// File: rtl/umai_pkg.sv
// Flit format shared by the UMAI flit unpacker: type encoding and the
// bit positions of the type, tag and payload fields in a 72-bit AIB flit.
package umai_pkg;

    typedef enum logic [1:0] {
        FT_WCMD  = 2'b00,
        FT_RCMD  = 2'b01,
        FT_WDATA = 2'b10,
        FT_RSVD  = 2'b11
    } flit_type_e;

    localparam int TYPE_HI        = 71;
    localparam int TYPE_LO        = 70;
    localparam int TAG_HI         = 69;
    localparam int TAG_LO         = 64;
    localparam int PAY_HI         = 63;
    localparam int PAY_LO         = 0;
    localparam int FLITS_PER_BEAT = 8;

endpackage

// File: rtl/umai_flit_unpacker.sv
// Unpacks 72-bit AIB flits into UMAI master write/read commands and
// 512-bit write data beats assembled from eight 64-bit payload flits.
module umai_flit_unpacker
    import umai_pkg::*;
#(
    parameter int FlitW = 72
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    input  logic [FlitW-1:0] i_rx_data,
    output logic             o_umai_mst_wcmd_valid,
    input  logic             i_umai_mst_wcmd_ready,
    output logic [31:0]      o_umai_mst_wcmd_addr,
    output logic [5:0]       o_umai_mst_wcmd_len,
    output logic             o_umai_mst_rcmd_valid,
    input  logic             i_umai_mst_rcmd_ready,
    output logic [31:0]      o_umai_mst_rcmd_addr,
    output logic [5:0]       o_umai_mst_rcmd_len,
    output logic             o_umai_mst_wvalid,
    input  logic             i_umai_mst_wready,
    output logic [511:0]     o_umai_mst_wdata,
    output logic             o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WCMD,
        ST_RCMD,
        ST_COLLECT,
        ST_BEAT
    } state_e;

    state_e      state;
    logic [31:0] cmd_addr;
    logic [5:0]  cmd_len;
    logic [2:0]  idx;
    logic [5:0]  cnt;
    logic [511:0] wdata;

    flit_type_e  ftype;
    logic [5:0]  tag;
    logic [63:0] payload;
    logic        rx_fire;

    assign ftype   = flit_type_e'(i_rx_data[TYPE_HI:TYPE_LO]);
    assign tag     = i_rx_data[TAG_HI:TAG_LO];
    assign payload = i_rx_data[PAY_HI:PAY_LO];

    // Ready decodes from state (not a separate flop) so it rises in the first cycle after reset release.
    assign o_rx_ready = i_rst_n && (state == ST_IDLE || state == ST_COLLECT);
    assign rx_fire    = i_rx_valid && o_rx_ready;

    assign o_umai_mst_wcmd_addr = cmd_addr;
    assign o_umai_mst_wcmd_len  = cmd_len;
    assign o_umai_mst_rcmd_addr = cmd_addr;
    assign o_umai_mst_rcmd_len  = cmd_len;
    assign o_umai_mst_wdata     = wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                 <= ST_IDLE;
            cmd_addr              <= '0;
            cmd_len               <= '0;
            idx                   <= '0;
            cnt                   <= '0;
            wdata                 <= '0;
            o_umai_mst_wcmd_valid <= 1'b0;
            o_umai_mst_rcmd_valid <= 1'b0;
            o_umai_mst_wvalid     <= 1'b0;
            o_err                 <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (ftype == FT_WCMD || ftype == FT_RCMD) begin
                            cmd_addr <= payload[31:0];
                            cmd_len  <= tag;
                            if (ftype == FT_WCMD) begin
                                state                 <= ST_WCMD;
                                o_umai_mst_wcmd_valid <= 1'b1;
                            end else begin
                                state                 <= ST_RCMD;
                                o_umai_mst_rcmd_valid <= 1'b1;
                            end
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ST_WCMD: begin
                    if (i_umai_mst_wcmd_ready) begin
                        o_umai_mst_wcmd_valid <= 1'b0;
                        idx                   <= '0;
                        cnt                   <= '0;
                        state                 <= ST_COLLECT;
                    end
                end
                ST_RCMD: begin
                    if (i_umai_mst_rcmd_ready) begin
                        o_umai_mst_rcmd_valid <= 1'b0;
                        state                 <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    // Out-of-order or wrong-type flits are swallowed without touching idx or wdata.
                    if (rx_fire) begin
                        if (ftype == FT_WDATA && tag[2:0] == idx) begin
                            wdata[{idx, 6'd0} +: 64] <= payload;
                            if (idx == 3'(FLITS_PER_BEAT - 1)) begin
                                state             <= ST_BEAT;
                                o_umai_mst_wvalid <= 1'b1;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ST_BEAT: begin
                    if (i_umai_mst_wready) begin
                        o_umai_mst_wvalid <= 1'b0;
                        if (cnt == cmd_len) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= cnt + 6'd1;
                            idx   <= '0;
                            state <= ST_COLLECT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umai_flit_unpacker.sv
// Randomized self-checking bench for umai_flit_unpacker with a flit-level reference model.
module tb_umai_flit_unpacker;

    localparam logic [1:0] T_WCMD  = 2'b00;
    localparam logic [1:0] T_RCMD  = 2'b01;
    localparam logic [1:0] T_WDATA = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid;
    logic         rx_ready;
    logic [71:0]  rx_data;
    logic         wcmd_valid, wcmd_ready;
    logic [31:0]  wcmd_addr;
    logic [5:0]   wcmd_len;
    logic         rcmd_valid, rcmd_ready;
    logic [31:0]  rcmd_addr;
    logic [5:0]   rcmd_len;
    logic         wvalid, wready;
    logic [511:0] wdata;
    logic         err;

    always #5 clk = ~clk;

    umai_flit_unpacker #(.FlitW(72)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_rx_valid            (rx_valid),
        .o_rx_ready            (rx_ready),
        .i_rx_data             (rx_data),
        .o_umai_mst_wcmd_valid (wcmd_valid),
        .i_umai_mst_wcmd_ready (wcmd_ready),
        .o_umai_mst_wcmd_addr  (wcmd_addr),
        .o_umai_mst_wcmd_len   (wcmd_len),
        .o_umai_mst_rcmd_valid (rcmd_valid),
        .i_umai_mst_rcmd_ready (rcmd_ready),
        .o_umai_mst_rcmd_addr  (rcmd_addr),
        .o_umai_mst_rcmd_len   (rcmd_len),
        .o_umai_mst_wvalid     (wvalid),
        .i_umai_mst_wready     (wready),
        .o_umai_mst_wdata      (wdata),
        .o_err                 (err)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [37:0]  wcmd_q[$];
    logic [37:0]  rcmd_q[$];
    logic [511:0] beat_q[$];
    int err_cnt = 0;
    int viol_cnt = 0;
    int stuck = 0;
    logic wr_rand = 1'b0;

    logic p_rst, p_wcv, p_wcr, p_rcv, p_rcr, p_wv, p_wr;
    logic [37:0]  p_wc, p_rc;
    logic [511:0] p_wd;

    function automatic logic [71:0] mk(input logic [1:0] t, input logic [5:0] tg, input logic [63:0] p);
        return {t, tg, p};
    endfunction

    // Observes handshakes at the negative edge and records protocol violations.
    initial begin
        p_rst = 1'b0; p_wcv = 1'b0; p_wcr = 1'b0; p_rcv = 1'b0; p_rcr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
        p_wc = '0; p_rc = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wcmd_valid && wcmd_ready) wcmd_q.push_back({wcmd_addr, wcmd_len});
                if (rcmd_valid && rcmd_ready) rcmd_q.push_back({rcmd_addr, rcmd_len});
                if (wvalid && wready) beat_q.push_back(wdata);
                if (err) err_cnt++;
                if (rx_ready && (wvalid || wcmd_valid || rcmd_valid)) viol_cnt++;
                if (p_rst) begin
                    if (p_wcv && !p_wcr && (!wcmd_valid || {wcmd_addr, wcmd_len} !== p_wc)) viol_cnt++;
                    if (p_rcv && !p_rcr && (!rcmd_valid || {rcmd_addr, rcmd_len} !== p_rc)) viol_cnt++;
                    if (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) viol_cnt++;
                end
            end
            p_rst = rst_n;
            p_wcv = wcmd_valid; p_wcr = wcmd_ready; p_wc = {wcmd_addr, wcmd_len};
            p_rcv = rcmd_valid; p_rcr = rcmd_ready; p_rc = {rcmd_addr, rcmd_len};
            p_wv  = wvalid;     p_wr  = wready;     p_wd = wdata;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_rand) wready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one flit and returns one time unit after the edge that accepted it.
    task automatic send_flit(input logic [71:0] f);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = f;
        @(negedge clk);
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) stuck++;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_beats(input int want);
        int i;
        i = 0;
        while (beat_q.size() < want && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
        wcmd_ready = 1'b0; rcmd_ready = 1'b0; wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b want 0", rx_ready); else n_pass++;
        n_total++; if ({wcmd_valid, rcmd_valid, wvalid, err} !== 4'b0) $display("FAIL reset_valids: got %b want 0000", {wcmd_valid, rcmd_valid, wvalid, err}); else n_pass++;
        n_total++; if ({wcmd_addr, wcmd_len} !== 38'd0) $display("FAIL reset_cmd: got %h want 0", {wcmd_addr, wcmd_len}); else n_pass++;
        n_total++; if (wdata !== 512'd0) $display("FAIL reset_wdata: got %h want 0", wdata); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (rx_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", rx_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_write();
        logic [511:0] exp;
        logic [63:0]  pl;
        logic         lat_cmd, lat_beat;
        int e0, v0;
        e0 = err_cnt; v0 = viol_cnt;
        wcmd_q.delete(); beat_q.delete();
        wcmd_ready = 1'b1; wready = 1'b1;
        exp = '0;
        send_flit(mk(T_WCMD, 6'd0, {32'($urandom), 32'h1000_0040}));
        lat_cmd = wcmd_valid;
        for (int k = 0; k < 8; k++) begin
            pl = {8{8'(k)}};
            exp[64*k +: 64] = pl;
            send_flit(mk(T_WDATA, {3'($urandom), 3'(k)}, pl));
        end
        lat_beat = wvalid;
        wait_beats(1);
        n_total++; if (lat_cmd !== 1'b1) $display("FAIL basic_cmd_latency: got %b want 1", lat_cmd); else n_pass++;
        n_total++; if (lat_beat !== 1'b1) $display("FAIL basic_beat_latency: got %b want 1", lat_beat); else n_pass++;
        n_total++; if (wcmd_q.size() != 1) $display("FAIL basic_wcmd_count: got %0d want 1", wcmd_q.size()); else n_pass++;
        n_total++; if ((wcmd_q.size() > 0 ? wcmd_q[0] : 38'bx) !== {32'h1000_0040, 6'd0}) $display("FAIL basic_wcmd_fields: got %h want %h", (wcmd_q.size() > 0 ? wcmd_q[0] : 38'bx), {32'h1000_0040, 6'd0}); else n_pass++;
        n_total++; if (beat_q.size() != 1) $display("FAIL basic_beat_count: got %0d want 1", beat_q.size()); else n_pass++;
        n_total++; if ((beat_q.size() > 0 ? beat_q[0] : 512'bx) !== exp) $display("FAIL basic_wdata: got %h want %h", (beat_q.size() > 0 ? beat_q[0] : 512'bx), exp); else n_pass++;
        n_total++; if (rx_ready !== 1'b1) $display("FAIL basic_idle: got %b want 1", rx_ready); else n_pass++;
        n_total++; if ((err_cnt - e0) != 0 || (viol_cnt - v0) != 0 || stuck != 0) $display("FAIL basic_protocol: got err=%0d viol=%0d stuck=%0d want 0", err_cnt - e0, viol_cnt - v0, stuck); else n_pass++;
    endtask

    task automatic test_rcmd_stall();
        int bad;
        bad = 0;
        rcmd_q.delete();
        rcmd_ready = 1'b0;
        send_flit(mk(T_RCMD, 6'd5, {32'($urandom), 32'hDEAD_BEE0}));
        repeat (10) begin
            @(negedge clk);
            if (!(rcmd_valid === 1'b1 && rcmd_addr === 32'hDEAD_BEE0 && rcmd_len === 6'd5 && rx_ready === 1'b0)) bad++;
            @(posedge clk);
            #1;
        end
        n_total++; if (rcmd_q.size() != 0) $display("FAIL rcmd_early: got %0d handshakes want 0", rcmd_q.size()); else n_pass++;
        rcmd_ready = 1'b1;
        @(posedge clk);
        #1;
        rcmd_ready = 1'b0;
        n_total++; if (bad != 0) $display("FAIL rcmd_stall_stable: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if ((rcmd_q.size() > 0 ? rcmd_q[0] : 38'bx) !== {32'hDEAD_BEE0, 6'd5}) $display("FAIL rcmd_fields: got %h want %h", (rcmd_q.size() > 0 ? rcmd_q[0] : 38'bx), {32'hDEAD_BEE0, 6'd5}); else n_pass++;
        n_total++; if ({rcmd_valid, rx_ready} !== 2'b01) $display("FAIL rcmd_back_to_idle: got %b want 01", {rcmd_valid, rx_ready}); else n_pass++;
    endtask

    task automatic test_long_burst();
        logic [511:0] exp_b [64];
        logic [63:0]  pl;
        logic [31:0]  addr;
        int mism, v0;
        v0 = viol_cnt; mism = 0;
        wcmd_q.delete(); beat_q.delete();
        addr = $urandom;
        wcmd_ready = 1'b1;
        wr_rand = 1'b1;
        send_flit(mk(T_WCMD, 6'd63, {32'd0, addr}));
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 8; k++) begin
                pl = {32'($urandom), 32'($urandom)};
                exp_b[b][64*k +: 64] = pl;
                send_flit(mk(T_WDATA, 6'(k), pl));
            end
        end
        wait_beats(64);
        wr_rand = 1'b0;
        for (int b = 0; b < 64 && b < beat_q.size(); b++)
            if (beat_q[b] !== exp_b[b]) mism++;
        n_total++; if (beat_q.size() != 64) $display("FAIL long_beat_count: got %0d want 64", beat_q.size()); else n_pass++;
        n_total++; if (mism != 0) $display("FAIL long_data: got %0d corrupted beats want 0", mism); else n_pass++;
        n_total++; if ((wcmd_q.size() > 0 ? wcmd_q[0] : 38'bx) !== {addr, 6'd63}) $display("FAIL long_wcmd: got %h want %h", (wcmd_q.size() > 0 ? wcmd_q[0] : 38'bx), {addr, 6'd63}); else n_pass++;
        n_total++; if ((viol_cnt - v0) != 0 || stuck != 0) $display("FAIL long_protocol: got viol=%0d stuck=%0d want 0", viol_cnt - v0, stuck); else n_pass++;
        @(posedge clk);
        #2;
        wready = 1'b1;
    endtask

    task automatic test_errors();
        logic [511:0] exp_b [2];
        logic [63:0]  pl;
        logic [31:0]  addr;
        int e0, mism;
        e0 = err_cnt; mism = 0;
        wcmd_q.delete(); beat_q.delete();
        wcmd_ready = 1'b1; wready = 1'b1;
        addr = $urandom;
        send_flit(mk(T_WDATA, 6'd0, {32'($urandom), 32'($urandom)}));
        send_flit(mk(T_WCMD, 6'd1, {32'd0, addr}));
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (b == 0 && k == 2) begin
                    send_flit(mk(T_RCMD, 6'd4, {32'($urandom), 32'($urandom)}));
                    send_flit(mk(T_RSVD, 6'd2, {32'($urandom), 32'($urandom)}));
                    send_flit(mk(T_WDATA, 6'd3, {32'($urandom), 32'($urandom)}));
                end
                pl = {32'($urandom), 32'($urandom)};
                exp_b[b][64*k +: 64] = pl;
                send_flit(mk(T_WDATA, 6'(k), pl));
            end
        end
        wait_beats(2);
        for (int b = 0; b < 2 && b < beat_q.size(); b++)
            if (beat_q[b] !== exp_b[b]) mism++;
        n_total++; if ((err_cnt - e0) != 4) $display("FAIL err_pulses: got %0d want 4", err_cnt - e0); else n_pass++;
        n_total++; if (beat_q.size() != 2) $display("FAIL err_beat_count: got %0d want 2", beat_q.size()); else n_pass++;
        n_total++; if (mism != 0) $display("FAIL err_burst_data: got %0d corrupted beats want 0", mism); else n_pass++;
        n_total++; if (wcmd_q.size() != 1 || wcmd_q[0] !== {addr, 6'd1}) $display("FAIL err_wcmd: got %0d cmds want 1 with %h", wcmd_q.size(), {addr, 6'd1}); else n_pass++;
        n_total++; if (rx_ready !== 1'b1 || stuck != 0) $display("FAIL err_idle: got ready=%b stuck=%0d want 1/0", rx_ready, stuck); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [511:0] exp;
        logic [63:0]  pl;
        logic [31:0]  addr;
        wcmd_q.delete(); beat_q.delete();
        wcmd_ready = 1'b1; wready = 1'b1;
        send_flit(mk(T_WCMD, 6'd3, {32'd0, 32'($urandom)}));
        for (int n = 0; n < 20; n++)
            send_flit(mk(T_WDATA, 6'(n % 8), {32'($urandom), 32'($urandom)}));
        n_total++; if (beat_q.size() != 2) $display("FAIL rst_pre_beats: got %0d want 2", beat_q.size()); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({rx_ready, wcmd_valid, rcmd_valid, wvalid, err} !== 5'b0) $display("FAIL rst_mid_ctrl: got %b want 00000", {rx_ready, wcmd_valid, rcmd_valid, wvalid, err}); else n_pass++;
        n_total++; if ({wcmd_addr, wcmd_len} !== 38'd0 || wdata !== 512'd0) $display("FAIL rst_mid_data: got cmd=%h wdata_nonzero=%b want 0", {wcmd_addr, wcmd_len}, |wdata); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wcmd_q.delete(); beat_q.delete();
        @(posedge clk);
        #1;
        addr = $urandom;
        exp = '0;
        send_flit(mk(T_WCMD, 6'd0, {32'd0, addr}));
        for (int k = 0; k < 8; k++) begin
            pl = {32'($urandom), 32'($urandom)};
            exp[64*k +: 64] = pl;
            send_flit(mk(T_WDATA, 6'(k), pl));
        end
        wait_beats(1);
        n_total++; if (wcmd_q.size() != 1 || wcmd_q[0] !== {addr, 6'd0}) $display("FAIL rst_new_wcmd: got %0d cmds want 1 with %h", wcmd_q.size(), {addr, 6'd0}); else n_pass++;
        n_total++; if (beat_q.size() != 1) $display("FAIL rst_new_beat_count: got %0d want 1", beat_q.size()); else n_pass++;
        n_total++; if ((beat_q.size() > 0 ? beat_q[0] : 512'bx) !== exp) $display("FAIL rst_new_wdata: got %h want %h", (beat_q.size() > 0 ? beat_q[0] : 512'bx), exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_rcmd_stall();
        test_long_burst();
        test_errors();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
